pipe_reg_chain: RTL
===================

// Module: pipe_reg_chain
// PURPOSE
//   Parametrised multi-lane pipeline register chain for the DSP datapath. Replaces
//   single enabled flops on pre-adder, multiplier and post-adder paths.
//   Carries LANES x WIDTH data through DEPTH stages under valid/ready flow control,
//   with clock enable, synchronous flush and per-lane load enables at stage 0.
// PARAMETERS
//   WIDTH   18  bits per lane
//   LANES   1   parallel lanes sharing one valid/ready pair
//   DEPTH   2   register stages; 0 = combinational bypass; legal range 0..8
// PORTS
//   clk        in   1            single clock, all state on rising edge
//   rst_n      in   1            synchronous, active-low reset
//   ce         in   1            clock enable; low = whole chain holds
//   flush      in   1            synchronous clear of all valid bits
//   lane_en    in   LANES        per-lane load enable at stage 0
//   in_data    in   WIDTH*LANES  lane l = in_data[l*WIDTH +: WIDTH]
//   in_valid   in   1            upstream beat present
//   in_ready   out  1            chain accepts beat this cycle
//   out_data   out  WIDTH*LANES  last-stage data
//   out_valid  out  1            last stage holds a beat
//   out_ready  in   1            downstream consumes beat this cycle
//   occupancy  out  4            valid stages held (only with PIPE_REG_CHAIN_OCC_EN)
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): all stage valid=0, all stage data=0;
//     out_valid=0, out_data=0, occupancy=0. Reset beats ce and flush.
//   - Per stage k: v[k], d[k]. adv[k] = ce & v[k-1] & (~v[k] | adv[k+1]) for
//     k>0, with adv[DEPTH] = out_ready (downstream). Ready ripples back
//     combinationally, so bubbles collapse and throughput is 1 beat/cycle.
//   - in_ready = ce & ~flush & (~v[0] | adv[1]). Transfer = in_valid & in_ready.
//   - Stage 0 load on transfer: lane l takes in_data lane l if lane_en[l], else
//     keeps its old d[0] lane. v[0] is set either way.
//   - Stage k>0 on adv[k]: d[k] <= d[k-1], v[k] <= 1. Stage vacated without
//     refill: v <= 0, data keeps last value (no clear).
//   - Latency: empty chain, out_ready=1: in beat at edge N shows on out at edge
//     N+DEPTH-1 (out_valid high DEPTH cycles after in_valid).
//   - ce=0: no state changes, in_ready=0. out_valid/out_data hold. Downstream
//     may see out_valid=1 but the beat is not popped.
//   - flush=1 (ce ignored): all v <= 0 next edge; data regs unchanged;
//     in_ready=0 so a concurrent in_valid beat is dropped.
//   - Full chain, out_ready=0: all stages hold, in_ready=0; no beat lost or
//     duplicated.
//   - DEPTH=0: out_data=in_data, out_valid=in_valid, in_ready=out_ready; ce,
//     flush and lane_en are ignored; no state.
// CONFIGURATION
//   - Macro PIPE_REG_CHAIN_OCC_EN defined: occupancy port exists and equals the
//     count of set v[k], registered, updated the same edge as v.
//   - Not defined: occupancy port and its counter are absent; all other
//     behaviour is identical.
// STRUCTURE
//   - Package pipe_reg_pkg: MAX_DEPTH=8, OCC_W=4, lane slice helper.
//   - Sub-module pipe_stage (WIDTH*LANES data + valid, load/clear inputs).
//     Instance it DEPTH times in a generate loop. Stage 0 adds the lane_en mux.
// TESTING
//   1 Reset: rst_n=0 with in_valid=1, WIDTH=18,LANES=2,DEPTH=3 -> out_valid=0,
//     out_data=0, in_ready=0 during reset. in_ready=1 the first cycle after.
//   2 Streaming: 10 beats 0x00001..0x0000A, out_ready=1 -> out order intact;
//     first out_valid 3 cycles after first in_valid; 1 beat/cycle.
//   3 Backpressure: fill chain, out_ready=0 for 5 cycles -> in_ready=0 after 3
//     accepted beats; release -> all beats out in order, none lost or duplicated.
//   4 Lane enable: load lanes {0x111,0x222}, then {0x333,0x444} with
//     lane_en=2'b01 -> second output beat = {0x333,0x222}.
//   5 Flush + ce: ce=0 for 4 cycles mid-stream -> outputs frozen; then flush with
//     in_valid=1 -> beat dropped, out_valid=0 next cycle, occupancy=0.
//   6 DEPTH=0 build: in_data=0x2AAAA, in_valid=1 -> out_data/out_valid same
//     cycle; in_ready tracks out_ready.

Source files
------------

// File: rtl/pipe_reg_pkg.sv
// Shared constants and helpers for the pipe_reg_chain pipeline register chain.
package pipe_reg_pkg;

    localparam int MAX_DEPTH = 8;
    localparam int OCC_W     = 4;

    // Bit offset of lane 'lane' in a packed multi-lane bus of 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One pipeline stage: W-bit data register plus valid bit with load/clear controls.
module pipe_stage #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         valid_q,
    output logic         valid_d,
    output logic [W-1:0] data_q
);

    logic [W-1:0] data_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; data is reset too, since it is visible on out_data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Multi-lane valid/ready pipeline register chain, DEPTH stages (0 = bypass).
// Optional occupancy counter: define PIPE_REG_CHAIN_OCC_EN.
module pipe_reg_chain
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int LANES = 1,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ce,
    input  logic                   flush,
    input  logic [LANES-1:0]       lane_en,
    input  logic [WIDTH*LANES-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH*LANES-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef PIPE_REG_CHAIN_OCC_EN
    ,
    output logic [OCC_W-1:0]       occupancy
`endif
);

    localparam int DW = WIDTH * LANES;

    if (DEPTH == 0) begin : g_bypass

        assign out_data  = in_data;
        assign out_valid = in_valid;
        assign in_ready  = out_ready;

        logic unused_bypass;
        assign unused_bypass = ^{clk, rst_n, ce, flush, lane_en};

`ifdef PIPE_REG_CHAIN_OCC_EN
        assign occupancy = '0;
`endif

    end else begin : g_chain

        logic          go;
        logic [DEPTH:0] adv;
        logic [DEPTH-1:0] v_q;
        logic [DEPTH-1:0] v_d;
        logic [DW-1:0] stage_q [DEPTH];
        logic [DW-1:0] lane_mux;

        assign go = ce & ~flush;

        // adv[0] is the input transfer; adv[DEPTH] is the downstream pop.
        // Ready ripples from the output back so a full chain drains and refills each cycle.
        always_comb begin
            adv        = '0;
            adv[DEPTH] = go & out_ready;
            for (int k = DEPTH - 1; k >= 1; k--) begin
                adv[k] = go & v_q[k-1] & (~v_q[k] | adv[k+1]);
            end
            in_ready = rst_n & go & (~v_q[0] | adv[1]);
            adv[0]   = in_valid & in_ready;
        end

        always_comb begin
            lane_mux = stage_q[0];
            for (int l = 0; l < LANES; l++) begin
                if (lane_en[l]) begin
                    lane_mux[lane_lsb(l, WIDTH) +: WIDTH] = in_data[lane_lsb(l, WIDTH) +: WIDTH];
                end
            end
        end

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic [DW-1:0] din;
            if (k == 0) begin : g_first
                assign din = lane_mux;
            end else begin : g_next
                assign din = stage_q[k-1];
            end

            pipe_stage #(.W(DW)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (adv[k]),
                .clear   (flush | adv[k+1]),
                .din     (din),
                .valid_q (v_q[k]),
                .valid_d (v_d[k]),
                .data_q  (stage_q[k])
            );
        end

        assign out_data  = stage_q[DEPTH-1];
        assign out_valid = v_q[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCC_EN
        logic [OCC_W-1:0] occ_q;
        logic [OCC_W-1:0] occ_d;

        always_comb begin
            occ_d = OCC_W'($countones(v_d));
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end

        assign occupancy = occ_q;
`else
        logic unused_v_d;
        assign unused_v_d = ^v_d;
`endif

    end

endmodule
